// File: rtl/mips_defs.sv
// Shared MIPS execute-stage definitions: multiply/divide opcodes, FSM states
// and the default multi-cycle latencies of the HI/LO unit.
package mips_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing {hi, lo}; zero latency,
// no handshake (the caller decides when the result is captured).
module md_compute
  import mips_defs::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        signed_div;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] divisor;
  logic [31:0] quo;
  logic [31:0] rem;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed divide is done on magnitudes so 0x80000000 / -1 wraps cleanly.
  assign signed_div  = (md_op == MD_DIV);
  assign mag_a       = (signed_div && src_a[31]) ? -src_a : src_a;
  assign mag_b       = (signed_div && src_b[31]) ? -src_b : src_b;
  assign div_by_zero = (src_b == 32'd0);
  assign divisor     = div_by_zero ? 32'd1 : mag_b;
  assign quo         = mag_a / divisor;
  assign rem         = mag_a % divisor;

  always_comb begin
    result = '0;
    case (md_op_e'(md_op))
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {(src_a[31] ? -rem : rem),
                          ((src_a[31] ^ src_b[31]) ? -quo : quo)};
      MD_DIVU:  result = {rem, quo};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO unit: mult/div run a fixed MULT_CYCLES/DIV_CYCLES with busy
// high, mthi/mtlo take one edge; starts arriving while busy are ignored.
module mult_div_unit
  import mips_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_wr_q, pend_wr_d;
  logic [63:0] result;
  logic        div_by_zero;

  md_compute u_compute (
    .md_op       (md_op),
    .src_a       (src_a),
    .src_b       (src_b),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (md_op_e'(md_op))
            MD_MULT, MD_MULTU: begin
              pend_d    = result;
              pend_wr_d = 1'b1;
              cnt_d     = CW'(MULT_CYCLES);
              busy_d    = 1'b1;
              state_d   = MD_RUN;
            end
            MD_DIV, MD_DIVU: begin
              // A zero divisor still occupies the unit but leaves HI/LO alone.
              pend_d    = result;
              pend_wr_d = !div_by_zero;
              cnt_d     = CW'(DIV_CYCLES);
              busy_d    = 1'b1;
              state_d   = MD_RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = MD_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: table of ops with hand-computed HI/LO
// and busy lengths, plus sequences for reset abort, busy-time starts and back-to-back.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_vec;
  int n_miss;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_hi   (rd_hi),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Drive an op from a negedge; returns at the negedge following acceptance.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd7;
  endtask

  // Counts negedges with busy high (bounded); ends at first negedge with busy low.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    start  = 1'b0;
    md_op  = 3'd7;
    src_a  = '0;
    src_b  = '0;
    rd_hi  = 1'b0;

    vecs[0]  = '{"mult_neg1x2",    3'd0, 32'hFFFFFFFF, 32'h00000002,  5, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1]  = '{"multu_ffx2",     3'd1, 32'hFFFFFFFF, 32'h00000002,  5, 32'h00000001, 32'hFFFFFFFE};
    vecs[2]  = '{"div_m7by2",      3'd2, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7by2",      3'd3, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4]  = '{"div_min_by_m1",  3'd2, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"mthi_11",        3'd4, 32'h00000011, 32'h00000000,  0, 32'h00000011, 32'h80000000};
    vecs[6]  = '{"mtlo_22",        3'd5, 32'h00000022, 32'h00000000,  0, 32'h00000011, 32'h00000022};
    vecs[7]  = '{"div_5by0",       3'd2, 32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[8]  = '{"mthi_deadbeef",  3'd4, 32'hDEADBEEF, 32'h00000000,  0, 32'hDEADBEEF, 32'h00000022};
    vecs[9]  = '{"mult_max_sq",    3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,  5, 32'h3FFFFFFF, 32'h00000001};
    vecs[10] = '{"div_7bym2",      3'd2, 32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{"nop_op6",        3'd6, 32'h12345678, 32'h9ABCDEF0,  0, 32'h00000001, 32'hFFFFFFFD};
    vecs[12] = '{"multu_ffxff",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001};

    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(cnt);
      check({vecs[i].name, "_busy_cycles"}, cnt, vecs[i].cycles);
      check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
      rd_hi = 1'b1;
      #1 check({vecs[i].name, "_rd_hi"}, rd_data, vecs[i].exp_hi);
      rd_hi = 1'b0;
      #1 check({vecs[i].name, "_rd_lo"}, rd_data, vecs[i].exp_lo);
      @(negedge clk);
    end

    // MTLO while a MULT runs is dropped; reads during RUN see the old HI/LO.
    issue(3'd4, 32'h0000AAAA, 32'h0);
    issue(3'd5, 32'h0000BBBB, 32'h0);
    issue(3'd0, 32'h00000006, 32'h00000007);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == 1) begin
        start = 1'b1;
        md_op = 3'd5;
        src_a = 32'h00000055;
        rd_hi = 1'b1;
        #1 check("run_rd_old_hi", rd_data, 32'h0000AAAA);
      end
      if (cnt == 2) begin
        start = 1'b0;
        md_op = 3'd7;
        rd_hi = 1'b0;
        #1 check("run_rd_old_lo", rd_data, 32'h0000BBBB);
      end
      @(negedge clk);
    end
    check("mult_mtlo_busy_cycles", cnt, 32'd5);
    check("mult_mtlo_hi", hi, 32'h00000000);
    check("mult_mtlo_lo", lo, 32'h0000002A);

    // Back-to-back MULT issued in the first idle cycle.
    issue(3'd0, 32'h00000002, 32'h00000003);
    wait_idle(cnt);
    check("b2b_busy_cycles", cnt, 32'd5);
    check("b2b_hi", hi, 32'h00000000);
    check("b2b_lo", lo, 32'h00000006);

    // Reset two cycles into a MULT aborts it without a commit.
    issue(3'd4, 32'h00000077, 32'h0);
    issue(3'd0, 32'h00000003, 32'h00000004);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_after_busy", {31'd0, busy}, 32'd0);
    check("rst_after_hi", hi, 32'd0);
    check("rst_after_lo", lo, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit for the 5-stage MIPS pipeline.
- Holds the architectural HI/LO registers.
- Executes mult/multu/div/divu with fixed multi-cycle latency and reports busy to the hazard unit.
- Supplies HI or LO for mfhi/mflo into the execute-stage result mux, which feeds the E/M pipeline register.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high after a mult/multu is accepted.
- DIV_CYCLES, 10, cycles busy stays high after a div/divu is accepted.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage instruction is a valid MD op this cycle (already gated by stall/flush).
- md_op  input  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 = no-op.
- src_a  input  32  forwarded rs value.
- src_b  input  32  forwarded rt value.
- rd_hi  input  1  read select: 1=HI, 0=LO.
- busy  output  1  registered; high while an operation is in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.
- rd_data  output  32  combinational: rd_hi ? hi : lo.

Behaviour:
- Reset (async, active-high):
  - hi=0, lo=0, busy=0, counter=0, state=IDLE, pending result regs=0.
  - Reset asserted mid-operation aborts it; HI/LO are not committed.
- States: IDLE, RUN.
- IDLE, start && md_op in {MULT..DIVU} at edge t:
  - Compute the result from src_a/src_b sampled at t into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from t, state -> RUN.
- RUN, each edge:
  - counter decrements.
  - At the edge where counter reaches 1 -> 0: hi<=pend_hi, lo<=pend_lo, busy<=0, state -> IDLE.
  - Net effect: busy is high for exactly N cycles after t, and the new HI/LO are visible in the cycle busy first reads 0.
- hi/lo outputs keep their old values throughout RUN.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit stalls D on (start_E && md instr) || busy; a violating start is a bench error.
- MTHI/MTLO in IDLE:
  - hi<=src_a or lo<=src_a at that edge.
  - Single-cycle; busy stays 0.
- md_op 6/7 with start: no effect.
- Arithmetic:
  - MULT: signed 32x32 -> 64; hi=[63:32], lo=[31:0].
  - MULTU: unsigned 32x32 -> 64.
  - DIV: signed; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
  - DIV of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (src_b=0): the op runs the full DIV_CYCLES with busy=1, but hi/lo keep their prior values.
- rd_data during busy returns old values; mfhi/mflo must be stalled by the hazard unit.
- No flush input: an accepted op always completes. Upstream gating of start handles squashed instructions.

Decomposition:
- Shared package (mips_defs):
  - MD_OP encodings (MD_MULT..MD_MTLO).
  - Default MULT_CYCLES/DIV_CYCLES constants.
- Optional sub-module md_compute: purely combinational; takes md_op, src_a, src_b and produces the 64-bit {pend_hi, pend_lo} and a div_by_zero flag.
- Counter/FSM and the HI/LO registers stay in mult_div_unit.

Test Plan:
- Reset mid-run:
  - MULT 3 x 4 accepted, reset asserted 2 cycles later.
  - Required: hi=lo=0 and busy=0 immediately (asynchronous); no commit afterwards.
- Signed vs unsigned multiply of 0xFFFFFFFF x 0x00000002:
  - MULT: busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - MULTU: hi=0x00000001, lo=0xFFFFFFFE.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2: busy high exactly 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2: lo=3, hi=1.
- Edge divides:
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIV 5/0 with prior hi=0x11, lo=0x22: busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI/MTLO:
  - MTHI 0xDEADBEEF in IDLE: hi updates the next edge, busy stays 0.
  - MTLO issued during a MULT's RUN: ignored; the MULT result commits normally.
- Readback:
  - rd_hi toggled during RUN returns the old hi/lo.
  - Back-to-back MULT accepted in the first cycle busy=0 commits 5 cycles later with the new operands.
